time_set_controller: RTL and testbench

//  Generates the MM:SS digit values that the 4-digit seven-segment display mux consumes.

---
 rtl/time_set_controller.sv | 182 ++++++++++++++++++
 tb/tb_time_set_controller.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/time_set_controller.sv
// time_set_controller
//   MM:SS time source for a 4-digit seven-segment display mux.
//   - Time runs on a 1 Hz enable.
//   - Two debounced pushbuttons select a set mode and increment the selected field.
//   - A per-digit blank mask blinks the field being edited.
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous active-low reset
//   tick_1hz  one-clk enable pulse per second
//   btn_mode  raw mode button (async, active-high)
//   btn_inc   raw increment button (async, active-high)
//   m1/m2     minutes tens (0-5) / units (0-9)
//   s1/s2     seconds tens (0-5) / units (0-9)
//   blank     1 = blank digit; bit0=s2, bit1=s1, bit2=m2, bit3=m1
//   mode      0=RUN, 1=SET_MIN, 2=SET_SEC
module time_set_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned BLINK_CYCLES    = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [2:0] m1,
  output logic [3:0] m2,
  output logic [2:0] s1,
  output logic [3:0] s2,
  output logic [3:0] blank,
  output logic [1:0] mode
);

  localparam logic [1:0] StRun    = 2'd0;
  localparam logic [1:0] StSetMin = 2'd1;
  localparam logic [1:0] StSetSec = 2'd2;

  localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned BlW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BlW-1:0] BlMax = BlW'(BLINK_CYCLES - 1);

  // Button index 0 = mode, 1 = inc.
  logic [1:0]     btn_raw;
  logic [1:0]     sync1_q, sync2_q;
  logic [1:0]     stable_q, stable_d;
  logic [DbW-1:0] db_cnt_q [2];
  logic [DbW-1:0] db_cnt_d [2];
  logic [1:0]     press;

  assign btn_raw = {btn_inc, btn_mode};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      stable_d[i] = stable_q[i];
      db_cnt_d[i] = db_cnt_q[i];
      press[i]    = 1'b0;
      if (sync2_q[i] == stable_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DbMax) begin
        stable_d[i] = sync2_q[i];
        db_cnt_d[i] = '0;
        // Pulse only on an accepted rising level; releases are silent.
        press[i]    = sync2_q[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  logic           mode_press, inc_press;
  logic [1:0]     mode_q, mode_d;
  logic [2:0]     m1_q, m1_d, s1_q, s1_d;
  logic [3:0]     m2_q, m2_d, s2_q, s2_d;
  logic [BlW-1:0] bl_cnt_q, bl_cnt_d;
  logic           ph_q, ph_d;
  logic [3:0]     blank_q, blank_d;
  logic           do_tick, step_sec, step_min, sec_carry;

  assign mode_press = press[0];
  assign inc_press  = press[1];

  always_comb begin
    unique case (mode_q)
      StRun:    mode_d = mode_press ? StSetMin : StRun;
      StSetMin: mode_d = mode_press ? StSetSec : StSetMin;
      StSetSec: mode_d = mode_press ? StRun : StSetSec;
      default:  mode_d = StRun;
    endcase
  end

  always_comb begin
    m1_d      = m1_q;
    m2_d      = m2_q;
    s1_d      = s1_q;
    s2_d      = s2_q;
    sec_carry = 1'b0;
    do_tick   = (mode_q == StRun) && tick_1hz;
    // A mode press in the same clk wins over an increment press.
    step_sec  = do_tick || ((mode_q == StSetSec) && inc_press && !mode_press);
    if (step_sec) begin
      if (s2_q >= 4'd9) begin
        s2_d = 4'd0;
        if (s1_q >= 3'd5) begin
          s1_d      = 3'd0;
          sec_carry = 1'b1;
        end else begin
          s1_d = s1_q + 3'd1;
        end
      end else begin
        s2_d = s2_q + 4'd1;
      end
    end
    // Only the running clock carries seconds into minutes.
    step_min = (do_tick && sec_carry) || ((mode_q == StSetMin) && inc_press && !mode_press);
    if (step_min) begin
      if (m2_q >= 4'd9) begin
        m2_d = 4'd0;
        m1_d = (m1_q >= 3'd5) ? 3'd0 : m1_q + 3'd1;
      end else begin
        m2_d = m2_q + 4'd1;
      end
    end
  end

  always_comb begin
    bl_cnt_d = bl_cnt_q;
    ph_d     = ph_q;
    if (mode_d == StRun || mode_d != mode_q) begin
      // Every set mode starts with the field visible.
      bl_cnt_d = '0;
      ph_d     = 1'b0;
    end else if (bl_cnt_q == BlMax) begin
      bl_cnt_d = '0;
      ph_d     = ~ph_q;
    end else begin
      bl_cnt_d = bl_cnt_q + 1'b1;
    end
    unique case (mode_d)
      StSetMin: blank_d = {ph_d, ph_d, 2'b00};
      StSetSec: blank_d = {2'b00, ph_d, ph_d};
      default:  blank_d = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
      mode_q   <= StRun;
      m1_q     <= '0;
      m2_q     <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      bl_cnt_q <= '0;
      ph_q     <= 1'b0;
      blank_q  <= '0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= db_cnt_d[i];
      mode_q   <= mode_d;
      m1_q     <= m1_d;
      m2_q     <= m2_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      bl_cnt_q <= bl_cnt_d;
      ph_q     <= ph_d;
      blank_q  <= blank_d;
    end
  end

  assign m1    = m1_q;
  assign m2    = m2_q;
  assign s1    = s1_q;
  assign s2    = s2_q;
  assign blank = blank_q;
  assign mode  = mode_q;

endmodule

// File: tb/tb_time_set_controller.sv
module tb_time_set_controller;

  logic       clk;
  logic       reset;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_inc;
  logic [2:0] m1;
  logic [3:0] m2;
  logic [2:0] s1;
  logic [3:0] s2;
  logic [3:0] blank;
  logic [1:0] mode;

  int n_checks = 0;
  int n_fail   = 0;

  time_set_controller #(
    .DEBOUNCE_CYCLES(4),
    .BLINK_CYCLES   (8)
  ) u_dut (
    .clk     (clk),
    .reset   (reset),
    .tick_1hz(tick_1hz),
    .btn_mode(btn_mode),
    .btn_inc (btn_inc),
    .m1      (m1),
    .m2      (m2),
    .s1      (s1),
    .s2      (s2),
    .blank   (blank),
    .mode    (mode)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [13:0] now;
  assign now = {m1, m2, s1, s2};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] bcd(input int mm, input int ss);
    return {3'(mm / 10), 4'(mm % 10), 3'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic check_time(input string tag, input int mm, input int ss);
    check_eq(tag, 32'(now), 32'(bcd(mm, ss)));
  endtask

  task automatic wait_clks(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic tick_pulse();
    @(negedge clk);
    tick_1hz = 1'b1;
    @(negedge clk);
    tick_1hz = 1'b0;
  endtask

  // which: 0 = mode, 1 = inc
  task automatic press(input int which);
    @(negedge clk);
    if (which == 0) btn_mode = 1'b1;
    else            btn_inc  = 1'b1;
    wait_clks(8);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    wait_clks(8);
  endtask

  task automatic press_n(input int which, input int n);
    for (int i = 0; i < n; i++) press(which);
  endtask

  // Hold the given buttons until mode reaches target (bounded), then check the
  // blink pattern from the transition clk onward.
  task automatic enter_and_check_blink(input logic bm, input logic bi, input logic [1:0] target,
                                       input logic [3:0] on_mask, input int n_samples,
                                       input string tag);
    int guard;
    @(negedge clk);
    btn_mode = bm;
    btn_inc  = bi;
    guard    = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (mode != target && guard < 20);
    check_eq({tag, "_mode"}, 32'(mode), 32'(target));
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    for (int k = 0; k < n_samples; k++) begin
      check_eq($sformatf("%s_blank_k%0d", tag, k), 32'(blank),
               32'((((k / 8) % 2) == 1) ? on_mask : 4'b0000));
      @(negedge clk);
    end
    wait_clks(8);
  endtask

  initial begin
    reset    = 1'b0;
    tick_1hz = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    wait_clks(3);
    check_time("reset_time", 0, 0);
    check_eq("reset_mode", 32'(mode), 32'd0);
    check_eq("reset_blank", 32'(blank), 32'd0);
    reset = 1'b1;
    wait_clks(2);

    // Run: 60 ticks count through a minute with one clk latency.
    for (int i = 1; i <= 60; i++) begin
      tick_pulse();
      check_time($sformatf("run_tick%0d", i), i / 60, i % 60);
    end
    check_eq("run_blank", 32'(blank), 32'd0);

    // SET_MIN: blink on minutes, ticks frozen, inc wraps minutes only.
    enter_and_check_blink(1'b1, 1'b0, 2'd1, 4'b1100, 32, "setmin");
    for (int i = 0; i < 3; i++) tick_pulse();
    check_time("setmin_frozen", 1, 0);
    press_n(1, 59);
    check_time("setmin_wrap", 0, 0);
    press_n(1, 59);
    check_time("setmin_59", 59, 0);

    // Simultaneous mode+inc: mode wins, minutes untouched, blink on seconds.
    enter_and_check_blink(1'b1, 1'b1, 2'd2, 4'b0011, 16, "setsec");
    check_time("simul_no_inc", 59, 0);
    press_n(1, 59);
    check_time("setsec_59", 59, 59);
    press(1);
    check_time("setsec_wrap_nocarry", 59, 0);
    press_n(1, 59);
    check_time("preload", 59, 59);
    press(0);
    check_eq("back_run_mode", 32'(mode), 32'd0);
    check_eq("back_run_blank", 32'(blank), 32'd0);
    tick_pulse();
    check_time("rollover", 0, 0);

    // Glitch rejection and hold-without-repeat in SET_SEC.
    press(0);
    press(0);
    check_eq("glitch_mode", 32'(mode), 32'd2);
    press_n(1, 7);
    check_time("glitch_pre", 0, 7);
    @(negedge clk);
    btn_inc = 1'b1;
    wait_clks(3);
    btn_inc = 1'b0;
    wait_clks(10);
    check_time("glitch_reject", 0, 7);
    @(negedge clk);
    btn_inc = 1'b1;
    wait_clks(20);
    btn_inc = 1'b0;
    wait_clks(10);
    check_time("hold_one_press", 0, 8);

    // Build 12:34 in SET_SEC, then reset mid-debounce.
    press_n(1, 26);
    press(0);
    press(0);
    press_n(1, 12);
    press(0);
    check_time("pre_reset_time", 12, 34);
    check_eq("pre_reset_mode", 32'(mode), 32'd2);
    @(negedge clk);
    btn_inc = 1'b1;
    wait_clks(3);
    #2 reset = 1'b0;
    #1;
    check_time("async_reset_time", 0, 0);
    check_eq("async_reset_mode", 32'(mode), 32'd0);
    check_eq("async_reset_blank", 32'(blank), 32'd0);
    btn_inc = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    wait_clks(20);
    check_time("post_reset_time", 0, 0);
    check_eq("post_reset_mode", 32'(mode), 32'd0);
    check_eq("post_reset_blank", 32'(blank), 32'd0);
    press(0);
    check_eq("post_reset_press", 32'(mode), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
